// File: rtl/kmc_useq_stack.sv
// ---------------------------------------------------------------------------
// kmc_useq_stack -- KMC11-family microsequencer with a hardware call/return stack
//
// Holds the program counter, the maintenance address/instruction registers and
// the writable control RAM. The decoder supplies sequencing controls and a
// condition vector. The PC advances by one, jumps, calls or returns.
//
// Optional feature macro: KMC_USEQ_STACK_EN
//   defined   -> call/return stack with depth SD, sticky overflow/underflow
//   undefined -> seqCALL behaves as seqJMP, seqRET is ignored, the stack
//                outputs are tied to zero
//
// Parameters: AW (PC/CRAM address width), IW (instruction width),
//             SD (stack depth), NC (number of condition inputs)
// Ports:
//   clk, rst, init            clock, sync active-high reset, device initialise
//   mntADDRWR/mntINSTWR       load maintenance address/instruction from mntDATA
//   mntDATA                   maintenance load data, max(AW,IW) bits
//   cramIN                    drive maintenance instruction onto cram
//   cramOUT, cramWR           maintenance write enable and strobe
//   pcCLKEN, cramCLKEN        PC/stack advance enable, CRAM read register enable
//   seqJMP/seqCALL/seqRET     decoded conditional jump/call/return
//   seqCOND, seqTARGET, cond  condition select, target address, condition vector
//   pc, mntADDR, mntINST      program counter and maintenance registers
//   cram                      current microinstruction
//   stkDEPTH, stkOVF, stkUNF  stack occupancy and sticky error flags
// ---------------------------------------------------------------------------
module kmc_useq_stack #(
   parameter int AW = 10,
   parameter int IW = 16,
   parameter int SD = 4,
   parameter int NC = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           init,
   input  logic                           mntADDRWR,
   input  logic                           mntINSTWR,
   input  logic [((AW > IW) ? AW : IW)-1:0] mntDATA,
   input  logic                           cramIN,
   input  logic                           cramOUT,
   input  logic                           cramWR,
   input  logic                           pcCLKEN,
   input  logic                           cramCLKEN,
   input  logic                           seqJMP,
   input  logic                           seqCALL,
   input  logic                           seqRET,
   input  logic [$clog2(NC)-1:0]          seqCOND,
   input  logic [AW-1:0]                  seqTARGET,
   input  logic [NC-1:0]                  cond,
   output logic [AW-1:0]                  pc,
   output logic [AW-1:0]                  mntADDR,
   output logic [IW-1:0]                  mntINST,
   output logic [IW-1:0]                  cram,
   output logic [$clog2(SD):0]            stkDEPTH,
   output logic                           stkOVF,
   output logic                           stkUNF
);

   localparam int PW = $clog2(SD) + 1;

   logic [IW-1:0] r_mem [0:(1 << AW)-1];
   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_mntADDR;
   logic [IW-1:0] r_mntINST;
   logic [IW-1:0] r_cramRd;

   logic          w_rst;
   logic          w_wr;
   logic          w_taken;
   logic [AW-1:0] w_pcInc;
   logic [AW-1:0] w_pcNext;

   assign w_rst   = rst | init;
   assign w_wr    = cramOUT & cramWR;
   assign w_taken = cond[seqCOND];
   assign w_pcInc = r_pc + AW'(1);

`ifdef KMC_USEQ_STACK_EN
   // Index width for the stack array; a depth of one still needs one bit.
   localparam int AIW = (SD > 1) ? $clog2(SD) : 1;

   logic [AW-1:0] r_stk [0:SD-1];
   logic [PW-1:0] r_sp;
   logic          r_ovf;
   logic          r_unf;
   logic [PW-1:0] w_spm1;
   logic [AW-1:0] w_top;
   logic          w_push;
   logic          w_pop;
   logic          w_ovfSet;
   logic          w_unfSet;

   assign w_spm1 = r_sp - PW'(1);
   assign w_top  = r_stk[w_spm1[AIW-1:0]];

   // Return outranks call, call outranks jump; all share one condition select,
   // so push and pop can never both happen in one cycle.
   always_comb begin
      w_pcNext = w_pcInc;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      w_ovfSet = 1'b0;
      w_unfSet = 1'b0;
      if (seqRET && w_taken) begin
         if (r_sp == '0) begin
            w_unfSet = 1'b1;
         end else begin
            w_pcNext = w_top;
            w_pop    = 1'b1;
         end
      end else if (seqCALL && w_taken) begin
         w_pcNext = seqTARGET;
         if (r_sp == PW'(SD)) w_ovfSet = 1'b1;
         else                 w_push   = 1'b1;
      end else if (seqJMP && w_taken) begin
         w_pcNext = seqTARGET;
      end
   end

   // Stack storage carries no reset; only the pointer defines validity.
   always_ff @(posedge clk) begin
      if (pcCLKEN && w_push) r_stk[r_sp[AIW-1:0]] <= w_pcInc;
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (pcCLKEN) begin
         if (w_push)     r_sp <= r_sp + PW'(1);
         else if (w_pop) r_sp <= w_spm1;
         if (w_ovfSet) r_ovf <= 1'b1;
         if (w_unfSet) r_unf <= 1'b1;
      end
   end

   assign stkDEPTH = r_sp;
   assign stkOVF   = r_ovf;
   assign stkUNF   = r_unf;
`else
   logic w_unused_ret;
   assign w_unused_ret = seqRET;

   // Without a stack a call is just a jump.
   always_comb begin
      w_pcNext = w_pcInc;
      if ((seqCALL || seqJMP) && w_taken) w_pcNext = seqTARGET;
   end

   assign stkDEPTH = '0;
   assign stkOVF   = 1'b0;
   assign stkUNF   = 1'b0;
`endif

   // CRAM contents survive reset; a write in the reset cycle still lands.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_mntADDR] <= r_mntINST;
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_pc      <= '0;
         r_mntADDR <= '0;
         r_mntINST <= '0;
         r_cramRd  <= '0;
      end else begin
         // An explicit address load beats the post-write increment.
         if (mntADDRWR) r_mntADDR <= mntDATA[AW-1:0];
         else if (w_wr) r_mntADDR <= r_mntADDR + AW'(1);
         if (mntINSTWR) r_mntINST <= mntDATA[IW-1:0];
         if (pcCLKEN)   r_pc      <= w_pcNext;
         // The read register holds during a write cycle.
         if (cramCLKEN && !w_wr) r_cramRd <= r_mem[r_pc];
      end
   end

   assign pc      = r_pc;
   assign mntADDR = r_mntADDR;
   assign mntINST = r_mntINST;
   assign cram    = cramIN ? r_mntINST : r_cramRd;

endmodule

// File: tb/tb_kmc_useq_stack.sv
// ---------------------------------------------------------------------------
// tb_kmc_useq_stack -- self-checking bench for kmc_useq_stack (AW=10, IW=16,
// SD=4, NC=8). Expectations follow the stack or no-stack behaviour depending
// on KMC_USEQ_STACK_EN.
// ---------------------------------------------------------------------------
module tb_kmc_useq_stack;

   logic        clk = 1'b0;
   logic        rst, init, mntADDRWR, mntINSTWR;
   logic [15:0] mntDATA;
   logic        cramIN, cramOUT, cramWR, pcCLKEN, cramCLKEN;
   logic        seqJMP, seqCALL, seqRET;
   logic [2:0]  seqCOND;
   logic [9:0]  seqTARGET;
   logic [7:0]  cond;
   logic [9:0]  pc, mntADDR;
   logic [15:0] mntINST, cram;
   logic [2:0]  stkDEPTH;
   logic        stkOVF, stkUNF;

   int checks = 0;
   int errors = 0;

   // Scoreboard of expected CRAM read-register words, in issue order.
   logic [15:0] cram_q[$];

   always #5 clk = ~clk;

   kmc_useq_stack #(.AW(10), .IW(16), .SD(4), .NC(8)) dut (
      .clk(clk), .rst(rst), .init(init), .mntADDRWR(mntADDRWR), .mntINSTWR(mntINSTWR),
      .mntDATA(mntDATA), .cramIN(cramIN), .cramOUT(cramOUT), .cramWR(cramWR),
      .pcCLKEN(pcCLKEN), .cramCLKEN(cramCLKEN), .seqJMP(seqJMP), .seqCALL(seqCALL),
      .seqRET(seqRET), .seqCOND(seqCOND), .seqTARGET(seqTARGET), .cond(cond),
      .pc(pc), .mntADDR(mntADDR), .mntINST(mntINST), .cram(cram),
      .stkDEPTH(stkDEPTH), .stkOVF(stkOVF), .stkUNF(stkUNF)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      rst = 0; init = 0; mntADDRWR = 0; mntINSTWR = 0; mntDATA = 16'h0;
      cramIN = 0; cramOUT = 0; cramWR = 0; pcCLKEN = 0; cramCLKEN = 0;
      seqJMP = 0; seqCALL = 0; seqRET = 0; seqCOND = 3'd0; seqTARGET = 10'h0;
      cond = 8'h01;
   endtask

   // Unconditional jump used to position the PC.
   task automatic goto(input logic [9:0] a);
      seqJMP = 1; seqCOND = 3'd0; cond = 8'hFF; seqTARGET = a; pcCLKEN = 1;
      tick;
      seqJMP = 0; pcCLKEN = 0;
   endtask

   task automatic test_reset;
      idle;
      rst = 1; pcCLKEN = 1; mntADDRWR = 1; mntDATA = 16'h0155; mntINSTWR = 1;
      tick;
      idle;
      checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 10'h000); end
      checks++; if (mntADDR !== 10'h000) begin errors++; $display("FAIL reset_mntADDR got %h want %h", mntADDR, 10'h000); end
      checks++; if (mntINST !== 16'h0000) begin errors++; $display("FAIL reset_mntINST got %h want %h", mntINST, 16'h0000); end
      checks++; if (cram !== 16'h0000) begin errors++; $display("FAIL reset_cram got %h want %h", cram, 16'h0000); end
      checks++; if (stkDEPTH !== 3'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", stkDEPTH); end
      checks++; if (stkOVF !== 1'b0 || stkUNF !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", stkOVF, stkUNF); end
   endtask

   task automatic test_maint_load;
      logic [15:0] words [3];
      logic [15:0] got;
      words[0] = 16'hA1B1; words[1] = 16'hC2D2; words[2] = 16'hE3F3;
      mntADDRWR = 1; mntDATA = 16'h03FE; tick; mntADDRWR = 0;
      checks++; if (mntADDR !== 10'h3FE) begin errors++; $display("FAIL mnt_addr_load got %h want %h", mntADDR, 10'h3FE); end
      for (int i = 0; i < 3; i++) begin
         mntINSTWR = 1; mntDATA = words[i]; tick; mntINSTWR = 0;
         checks++; if (mntINST !== words[i]) begin errors++; $display("FAIL mnt_inst_load got %h want %h", mntINST, words[i]); end
         cramOUT = 1; cramWR = 1; tick; cramOUT = 0; cramWR = 0;
      end
      checks++; if (mntADDR !== 10'h001) begin errors++; $display("FAIL mnt_addr_wrap got %h want %h", mntADDR, 10'h001); end
      goto(10'h3FE);
      // Read back through the PC: each edge registers mem[pc] and advances pc.
      cramCLKEN = 1; pcCLKEN = 1;
      for (int i = 0; i < 3; i++) begin
         cram_q.push_back(words[i]);
         tick;
         got = cram_q.pop_front();
         checks++; if (cram !== got) begin errors++; $display("FAIL cram_readback%0d got %h want %h", i, cram, got); end
      end
      cramCLKEN = 0; pcCLKEN = 0;
      checks++; if (pc !== 10'h001) begin errors++; $display("FAIL readback_pc got %h want %h", pc, 10'h001); end
      // Write plus address load in one cycle: load wins, read register holds.
      goto(10'h3FE);
      cramCLKEN = 1; cramOUT = 1; cramWR = 1; mntADDRWR = 1; mntDATA = 16'h0100;
      tick;
      cramCLKEN = 0; cramOUT = 0; cramWR = 0; mntADDRWR = 0;
      checks++; if (mntADDR !== 10'h100) begin errors++; $display("FAIL addr_load_wins got %h want %h", mntADDR, 10'h100); end
      checks++; if (cram !== 16'hE3F3) begin errors++; $display("FAIL cram_hold_on_write got %h want %h", cram, 16'hE3F3); end
   endtask

   task automatic test_cram_in;
      mntINSTWR = 1; mntDATA = 16'h5A5A; tick; mntINSTWR = 0;
      cramIN = 1; #1;
      checks++; if (cram !== 16'h5A5A) begin errors++; $display("FAIL cramIN_sel got %h want %h", cram, 16'h5A5A); end
      cramIN = 0; #1;
      checks++; if (cram !== 16'hE3F3) begin errors++; $display("FAIL cramIN_desel got %h want %h", cram, 16'hE3F3); end
   endtask

   task automatic test_sequencing;
      goto(10'h3FF);
      pcCLKEN = 1; tick;
      checks++; if (pc !== 10'h000) begin errors++; $display("FAIL pc_wrap got %h want %h", pc, 10'h000); end
      pcCLKEN = 1; tick;
      checks++; if (pc !== 10'h001) begin errors++; $display("FAIL pc_inc got %h want %h", pc, 10'h001); end
      pcCLKEN = 0; seqJMP = 1; cond = 8'hFF; seqTARGET = 10'h2AA; tick; tick;
      seqJMP = 0;
      checks++; if (pc !== 10'h001) begin errors++; $display("FAIL pc_hold got %h want %h", pc, 10'h001); end
   endtask

   task automatic test_cond_jump;
      goto(10'h020);
      seqJMP = 1; seqCOND = 3'd3; seqTARGET = 10'h155; pcCLKEN = 1; cond = 8'h01;
      tick;
      checks++; if (pc !== 10'h021) begin errors++; $display("FAIL jmp_not_taken got %h want %h", pc, 10'h021); end
      cond = 8'h09; tick;
      checks++; if (pc !== 10'h155) begin errors++; $display("FAIL jmp_taken got %h want %h", pc, 10'h155); end
      seqJMP = 0; pcCLKEN = 0;
   endtask

   task automatic test_nested_calls;
      logic [9:0] ret_q[$];
      logic [9:0] site, tgt, exp_pc;
      goto(10'h010);
      seqCOND = 3'd0; cond = 8'hFF; pcCLKEN = 1;
      for (int i = 0; i < 4; i++) begin
         site = 10'(10'h010 * (i + 1));
         tgt  = (i == 3) ? 10'h200 : 10'(site + 10'h010);
         ret_q.push_front(10'(site + 10'h001));
         seqCALL = 1; seqTARGET = tgt; tick;
         checks++; if (pc !== tgt) begin errors++; $display("FAIL call%0d_pc got %h want %h", i, pc, tgt); end
      end
      seqCALL = 0;
`ifdef KMC_USEQ_STACK_EN
      checks++; if (stkDEPTH !== 3'd4) begin errors++; $display("FAIL nest_depth got %0d want 4", stkDEPTH); end
`else
      checks++; if (stkDEPTH !== 3'd0) begin errors++; $display("FAIL nest_depth got %0d want 0", stkDEPTH); end
`endif
      exp_pc = 10'h200;
      for (int i = 0; i < 4; i++) begin
         seqRET = 1; tick;
`ifdef KMC_USEQ_STACK_EN
         exp_pc = ret_q.pop_front();
`else
         exp_pc = 10'(exp_pc + 10'h001);
`endif
         checks++; if (pc !== exp_pc) begin errors++; $display("FAIL ret%0d_pc got %h want %h", i, pc, exp_pc); end
      end
      seqRET = 0; pcCLKEN = 0;
      checks++; if (stkDEPTH !== 3'd0) begin errors++; $display("FAIL unnest_depth got %0d want 0", stkDEPTH); end
      checks++; if (stkOVF !== 1'b0 || stkUNF !== 1'b0) begin errors++; $display("FAIL nest_flags got %b%b want 00", stkOVF, stkUNF); end
   endtask

   task automatic test_overflow_underflow;
      logic [9:0] exp_pc;
      logic       exp_flag;
`ifdef KMC_USEQ_STACK_EN
      exp_flag = 1'b1;
`else
      exp_flag = 1'b0;
`endif
      goto(10'h100);
      seqCOND = 3'd0; cond = 8'hFF; pcCLKEN = 1;
      for (int i = 0; i < 5; i++) begin
         seqCALL = 1; seqTARGET = 10'(10'h110 + 10'h010 * i); tick;
      end
      seqCALL = 0;
      checks++; if (pc !== 10'h150) begin errors++; $display("FAIL ovf_pc got %h want %h", pc, 10'h150); end
      checks++; if (stkOVF !== exp_flag) begin errors++; $display("FAIL ovf_flag got %b want %b", stkOVF, exp_flag); end
`ifdef KMC_USEQ_STACK_EN
      checks++; if (stkDEPTH !== 3'd4) begin errors++; $display("FAIL ovf_depth got %0d want 4", stkDEPTH); end
`endif
      exp_pc = 10'h150;
      for (int i = 0; i < 5; i++) begin
         seqRET = 1; tick;
`ifdef KMC_USEQ_STACK_EN
         exp_pc = (i < 4) ? 10'(10'h131 - 10'h010 * i) : 10'(exp_pc + 10'h001);
`else
         exp_pc = 10'(exp_pc + 10'h001);
`endif
         checks++; if (pc !== exp_pc) begin errors++; $display("FAIL unf_ret%0d_pc got %h want %h", i, pc, exp_pc); end
      end
      seqRET = 0; pcCLKEN = 0;
      checks++; if (stkUNF !== exp_flag) begin errors++; $display("FAIL unf_flag got %b want %b", stkUNF, exp_flag); end
      checks++; if (stkOVF !== exp_flag) begin errors++; $display("FAIL ovf_sticky got %b want %b", stkOVF, exp_flag); end
      init = 1; tick; init = 0;
      checks++; if (stkOVF !== 1'b0 || stkUNF !== 1'b0) begin errors++; $display("FAIL init_flags got %b%b want 00", stkOVF, stkUNF); end
      checks++; if (pc !== 10'h000) begin errors++; $display("FAIL init_pc got %h want %h", pc, 10'h000); end
      checks++; if (stkDEPTH !== 3'd0) begin errors++; $display("FAIL init_depth got %0d want 0", stkDEPTH); end
   endtask

   task automatic test_priority;
      logic [9:0] exp_pc;
      goto(10'h080);
      seqCOND = 3'd0; cond = 8'hFF; pcCLKEN = 1;
      seqCALL = 1; seqTARGET = 10'h300; tick;
      checks++; if (pc !== 10'h300) begin errors++; $display("FAIL prio_call got %h want %h", pc, 10'h300); end
      seqRET = 1; seqCALL = 1; seqJMP = 1; seqTARGET = 10'h3A0; tick;
`ifdef KMC_USEQ_STACK_EN
      exp_pc = 10'h081;
`else
      exp_pc = 10'h3A0;
`endif
      seqRET = 0; seqCALL = 0; seqJMP = 0; pcCLKEN = 0;
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL prio_ret_over_call got %h want %h", pc, exp_pc); end
      checks++; if (stkDEPTH !== 3'd0) begin errors++; $display("FAIL prio_depth got %0d want 0", stkDEPTH); end
   endtask

   task automatic test_reset_mid_write;
      logic [15:0] got;
      mntADDRWR = 1; mntDATA = 16'h0050; tick; mntADDRWR = 0;
      mntINSTWR = 1; mntDATA = 16'h7777; tick; mntINSTWR = 0;
      rst = 1; cramOUT = 1; cramWR = 1; pcCLKEN = 1; seqJMP = 1; cond = 8'hFF; seqTARGET = 10'h222;
      tick;
      idle;
      checks++; if (pc !== 10'h000) begin errors++; $display("FAIL rst_mid_pc got %h want %h", pc, 10'h000); end
      checks++; if (mntADDR !== 10'h000 || mntINST !== 16'h0000) begin errors++; $display("FAIL rst_mid_mnt got %h/%h want 000/0000", mntADDR, mntINST); end
      goto(10'h050);
      cramCLKEN = 1;
      cram_q.push_back(16'h7777);
      tick;
      cramCLKEN = 0;
      got = cram_q.pop_front();
      checks++; if (cram !== got) begin errors++; $display("FAIL rst_mid_write got %h want %h", cram, got); end
   endtask

   initial begin
      idle;
      rst = 1;
      test_reset;
      test_maint_load;
      test_cram_in;
      test_sequencing;
      test_cond_jump;
      test_nested_calls;
      test_overflow_underflow;
      test_priority;
      test_reset_mid_write;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
